hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: per-register latency countdown for decode stalls plus
// execute-stage operand forwarding from the memory and writeback stages.

// One forwarding lane: picks the freshest producer for a single source operand.
module hs_fwd_lane #(
    parameter int W = 32
) (
    input  logic [4:0]   rs,
    input  logic [4:0]   rd_m,
    input  logic         we_m,
    input  logic [4:0]   rd_w,
    input  logic         we_w,
    input  logic [W-1:0] rde,
    input  logic [W-1:0] alu_m,
    input  logic [W-1:0] res_w,
    output logic [1:0]   sel,
    output logic [W-1:0] src
);

    // Memory stage wins over writeback; r0 is hardwired and never forwarded.
    always_comb begin
        sel = 2'b00;
        if (rs != 5'd0) begin
            if (we_m && rd_m == rs)
                sel = 2'b10;
            else if (we_w && rd_w == rs)
                sel = 2'b01;
        end
    end

    // Operand mux; the unused 11 code falls back to register-file data.
    always_comb begin
        case (sel)
            2'b10:   src = alu_m;
            2'b01:   src = res_w;
            default: src = rde;
        endcase
    end

endmodule

module hazard_scoreboard #(
    parameter int W       = 32,
    parameter int NSRC    = 2,
    parameter int LAT_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         IssueD,
    input  logic [NSRC*5-1:0]            RsD,
    input  logic [4:0]                   RdD,
    input  logic                         RegWriteD,
    input  logic [$clog2(LAT_MAX+1)-1:0] LatD,
    input  logic                         FlushE,
    input  logic                         HoldAll,
    input  logic [NSRC*W-1:0]            RDE,
    input  logic [W-1:0]                 ALUResultM,
    input  logic [W-1:0]                 ResultW,
    output logic                         StallD,
    output logic                         BubbleE,
    output logic [NSRC*2-1:0]            ForwardSelE,
    output logic [NSRC*W-1:0]            SrcE
);

    localparam int CW = $clog2(LAT_MAX + 1);

    // Execute needs sources for forwarding; later stages only carry the destination.
    typedef struct packed {
        logic [NSRC-1:0][4:0] rs;
        logic [4:0]           rd;
        logic                 we;
    } ex_tag_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
    } dst_tag_t;

    logic [CW-1:0]        cnt [32];
    logic [NSRC-1:0][4:0] rs_d;
    logic                 accept;
    logic [CW-1:0]        lat_eff;
    ex_tag_t              tag_d;
    ex_tag_t              tag_e;
    dst_tag_t             tag_m;
    dst_tag_t             tag_w;

    assign rs_d = RsD;

    // A source still counting down blocks decode; r0 never blocks.
    always_comb begin
        StallD = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (IssueD && rs_d[s] != 5'd0 && cnt[rs_d[s]] != '0)
                StallD = 1'b1;
        end
    end

    assign BubbleE = (StallD & ~HoldAll) | FlushE;
    assign accept  = IssueD & ~StallD & ~FlushE & ~HoldAll;

    // Count holds cycles remaining before the result is forwardable; latency 0 acts as 1.
    assign lat_eff = (LatD == '0) ? '0 : LatD - CW'(1);

    // Per-register countdown: new issue overrides flush, flush overrides decay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++)
                cnt[r] <= '0;
        end else if (!HoldAll) begin
            for (int r = 1; r < 32; r++) begin
                if (accept && RegWriteD && RdD == 5'(r))
                    cnt[r] <= lat_eff;
                else if (FlushE && tag_e.we && tag_e.rd == 5'(r))
                    cnt[r] <= '0;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CW'(1);
            end
        end
    end

    // Decode tag; an empty decode slot becomes an all-zero tag.
    always_comb begin
        tag_d = '0;
        if (IssueD) begin
            tag_d.rs = rs_d;
            tag_d.rd = RdD;
            tag_d.we = RegWriteD;
        end
    end

    // Stage tag pipeline; a flush also kills the instruction leaving execute.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_e <= '0;
            tag_m <= '0;
            tag_w <= '0;
        end else if (!HoldAll) begin
            tag_w <= tag_m;
            tag_m <= FlushE ? '0 : dst_tag_t'{rd: tag_e.rd, we: tag_e.we};
            tag_e <= BubbleE ? '0 : tag_d;
        end
    end

    // One forwarding lane per source operand.
    for (genvar s = 0; s < NSRC; s++) begin : g_lane
        hs_fwd_lane #(.W(W)) u_lane (
            .rs    (tag_e.rs[s]),
            .rd_m  (tag_m.rd),
            .we_m  (tag_m.we),
            .rd_w  (tag_w.rd),
            .we_w  (tag_w.we),
            .rde   (RDE[s*W +: W]),
            .alu_m (ALUResultM),
            .res_w (ResultW),
            .sel   (ForwardSelE[s*2 +: 2]),
            .src   (SrcE[s*W +: W])
        );
    end

endmodule
